// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: widths, opcode map and output-stage occupancy states.
// The opcode localparams are also consumed by the upstream opcode decoder.
package alsu_pkg;

    localparam int ALSU_DATA_W  = 4;
    localparam int ALSU_OP_W    = 6;
    localparam int ALSU_NUM_OPS = 40;

    localparam logic [ALSU_OP_W-1:0] OP_ADD    = 6'd0;
    localparam logic [ALSU_OP_W-1:0] OP_SUB    = 6'd1;
    localparam logic [ALSU_OP_W-1:0] OP_INC    = 6'd2;
    localparam logic [ALSU_OP_W-1:0] OP_DEC    = 6'd3;
    localparam logic [ALSU_OP_W-1:0] OP_AND    = 6'd4;
    localparam logic [ALSU_OP_W-1:0] OP_OR     = 6'd5;
    localparam logic [ALSU_OP_W-1:0] OP_XOR    = 6'd6;
    localparam logic [ALSU_OP_W-1:0] OP_NOT    = 6'd7;
    localparam logic [ALSU_OP_W-1:0] OP_SHL    = 6'd8;
    localparam logic [ALSU_OP_W-1:0] OP_SHR    = 6'd9;
    localparam logic [ALSU_OP_W-1:0] OP_ROL    = 6'd10;
    localparam logic [ALSU_OP_W-1:0] OP_ROR    = 6'd11;
    localparam logic [ALSU_OP_W-1:0] OP_PARITY = 6'd38;
    localparam logic [ALSU_OP_W-1:0] OP_LAST   = 6'd39;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/alsu_fifo_mem.sv
// Storage array for the ALSU result FIFO: synchronous write, asynchronous read.
module alsu_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alsu_result_fifo.sv
// Registered output stage of the ALSU: first-word-fall-through result FIFO with
// head parity and sticky overflow / illegal-opcode flags.
module alsu_result_fifo
    import alsu_pkg::*;
#(
    parameter int DATA_W = ALSU_DATA_W,
    parameter int OP_W   = ALSU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [OP_W-1:0]          in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [OP_W-1:0]          out_op,
    output logic                     out_parity,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     illegal_op,
    input  logic                     flag_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OP_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OP_W-1:0]  NUM_OPS_C = OP_W'(ALSU_NUM_OPS);

    occ_e             occ_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic             empty, full;
    logic             hs, push, pop;
    logic [ENT_W-1:0] head;

    alsu_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_op, in_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Status comes only from registered occupancy, so in_ready never sees out_ready.
    assign empty = (occ_q == OCC_EMPTY);
    assign full  = (occ_q == OCC_FULL);

    assign hs   = in_valid && !full;
    assign push = hs && (in_op < NUM_OPS_C);
    assign pop  = !empty && out_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A set event in the same cycle as flag_clr takes priority.
    always_comb begin
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (flag_clr) begin
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
        end
        if (in_valid && full) begin
            overflow_d = 1'b1;
        end
        if (hs && !push) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        occ_q <= (count_d == DEPTH_C) ? OCC_FULL : OCC_PARTIAL;
                    end
                end
                OCC_PARTIAL: begin
                    if (count_d == DEPTH_C) begin
                        occ_q <= OCC_FULL;
                    end else if (count_d == '0) begin
                        occ_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        occ_q <= OCC_PARTIAL;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : head[DATA_W-1:0];
    assign out_op     = empty ? '0 : head[DATA_W +: OP_W];
    assign out_parity = ^out_data;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign illegal_op = illegal_q;

endmodule
